// File: rtl/input_port_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : input_port_buffer_if
// Brief   : Upstream link and arbiter-side signals of one router input port
// Revision: 1.0
// ============================================================================
interface input_port_buffer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_tail;
  logic              in_ready;
  logic              req;
  logic              block;
  logic [DATA_W-1:0] out_data;
  logic              out_tail;
  logic              pop;

  // Buffer side: takes flits from the link and the arbiter's block.
  modport slave (
    input  in_valid, in_data, in_tail, block,
    output in_ready, req, out_data, out_tail, pop
  );

  // Environment side: upstream link plus downstream arbiter.
  modport master (
    output in_valid, in_data, in_tail, block,
    input  in_ready, req, out_data, out_tail, pop
  );
endinterface
`default_nettype wire

// File: rtl/input_port_buffer.sv
`default_nettype none
// ============================================================================
// Module  : input_port_buffer
// Brief   : FWFT flit FIFO feeding one arbiter input, with framing and stall count
// Revision: 1.0
// ============================================================================
module input_port_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  wire                   clk,
  input  wire                   rst,
  input_port_buffer_if.slave    bus,
  output logic                  pkt_active,
  output logic [ADDR_W:0]       count,
  output logic [7:0]            stall_cnt
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE    = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE    = 1;
  localparam logic [7:0]        STALL_MAX  = 8'hFF;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  state_t            state_q, state_d;
  logic [7:0]        stall_q, stall_d;
  logic              push;
  logic              pop_fire;

  // Handshake outputs depend only on registers and block, never on in_valid.
  assign bus.in_ready = (count_q != FULL_COUNT);
  assign bus.req      = (count_q != '0);
  assign bus.pop      = bus.req & ~bus.block;
  assign {bus.out_tail, bus.out_data} = mem_q[rd_ptr_q];

  assign push     = bus.in_valid & bus.in_ready;
  assign pop_fire = bus.pop;

  assign pkt_active = (state_q == ACTIVE);
  assign count      = count_q;
  assign stall_cnt  = stall_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;

    if (push)
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_fire)
      rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (bus.req && bus.block && (stall_q != STALL_MAX))
      stall_d = stall_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop_fire && !bus.out_tail) state_d = ACTIVE;
      ACTIVE:  if (pop_fire && bus.out_tail)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Storage is intentionally left unreset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {bus.in_tail, bus.in_data};
  end

endmodule
`default_nettype wire

// File: tb/tb_input_port_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_port_buffer
// Brief   : Directed scoreboard bench for input_port_buffer
// Revision: 1.0
// ============================================================================
module tb_input_port_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_active;
  logic [2:0] count;
  logic [7:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [8:0] sb[$];
  int         m_cnt;
  bit         m_active;
  int         m_stall;

  input_port_buffer_if #(.DATA_W(8)) bus ();

  input_port_buffer #(
    .DATA_W(8),
    .DEPTH (DEPTH),
    .ADDR_W(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pkt_active(pkt_active),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt    = 0;
    m_active = 1'b0;
    m_stall  = 0;
  endtask

  task automatic check_outputs(input logic b);
    logic m_req;
    m_req = (m_cnt != 0);
    chk("in_ready",   {31'd0, bus.in_ready}, {31'd0, (m_cnt != DEPTH)});
    chk("req",        {31'd0, bus.req},      {31'd0, m_req});
    chk("pop",        {31'd0, bus.pop},      {31'd0, m_req & ~b});
    chk("count",      {29'd0, count},        m_cnt);
    chk("pkt_active", {31'd0, pkt_active},   {31'd0, m_active});
    chk("stall_cnt",  {24'd0, stall_cnt},    m_stall);
    if (m_cnt != 0)
      chk("head", {23'd0, bus.out_tail, bus.out_data}, {23'd0, sb[0]});
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic t, input logic b);
    logic m_push, m_pop;
    logic [8:0] head;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_tail  = t;
    bus.block    = b;
    #1;
    check_outputs(b);
    m_pop  = (m_cnt != 0) && !b;
    m_push = v && (m_cnt != DEPTH);
    if ((m_cnt != 0) && b && (m_stall < 255))
      m_stall++;
    if (m_pop) begin
      head     = sb.pop_front();
      m_active = !head[8];
      m_cnt--;
    end
    if (m_push) begin
      sb.push_back({t, d});
      m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_tail  = 1'b0;
    bus.block    = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check_outputs(1'b0);
    rst = 1'b0;

    // Blocked while empty: nothing requested, stall count must not move.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Fill to full under block; 0x15 is refused at full.
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    cycle(1'b1, 8'h12, 1'b0, 1'b1);
    cycle(1'b1, 8'h13, 1'b0, 1'b1);
    cycle(1'b1, 8'h14, 1'b0, 1'b1);
    cycle(1'b1, 8'h15, 1'b0, 1'b1);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_head",  {24'd0, bus.out_data}, 32'h11);

    // Unblock at full: pop happens, push of held 0x15 is rejected.
    cycle(1'b1, 8'h15, 1'b0, 1'b0);
    chk("after_full_pop_count", {29'd0, count}, 32'd3);

    // Streaming across pointer wrap: count stays at 3.
    cycle(1'b1, 8'h15, 1'b0, 1'b0);
    cycle(1'b1, 8'h16, 1'b0, 1'b0);
    cycle(1'b1, 8'h17, 1'b0, 1'b0);
    cycle(1'b1, 8'h18, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drained_count", {29'd0, count}, 32'd0);

    // Framing: 3-flit packet then single-flit packet.
    cycle(1'b1, 8'h21, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h23, 1'b1, 1'b0);
    cycle(1'b1, 8'h24, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-packet with 3 flits buffered.
    cycle(1'b1, 8'h31, 1'b0, 1'b1);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b1);
    cycle(1'b1, 8'h34, 1'b0, 1'b1);
    chk("pre_reset_count",  {29'd0, count},      32'd3);
    chk("pre_reset_active", {31'd0, pkt_active}, 32'd1);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Fresh data after reset must not show stale entries.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Stall counter saturation.
    cycle(1'b1, 8'h41, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("stall_sat", {24'd0, stall_cnt}, 32'd255);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_port_buffer.md
# input_port_buffer

Per-port input stage of the router switch: buffers incoming flits from one link in a small first-word-fall-through FIFO. It presents a request to the downstream fixed-priority arbiter and consumes that arbiter's per-port block signal, popping one flit per unblocked cycle. One instance sits in front of each arbiter input. The arbiter's highest-priority input has no block signal, so that instance has its `block` input tied to 0. The block also tracks packet framing and counts blocked cycles for debug.

## Interface

- `DATA_W`, default 8: flit payload width.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, minimum 2.
- `ADDR_W`, default 2: log2(DEPTH).
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  upstream presents a flit this cycle.
- `in_data`  input  DATA_W  flit payload.
- `in_tail`  input  1  flit is the last flit of its packet.
- `in_ready`  output  1  buffer accepts a flit this cycle.
- `req`  output  1  request to the arbiter (drives its portN input).
- `block`  input  1  arbiter's portN_block for this port; tie to 0 on the highest-priority port.
- `out_data`  output  DATA_W  head-of-FIFO payload, valid while `req`=1.
- `out_tail`  output  1  tail bit of the head flit.
- `pop`  output  1  head flit is transferred this cycle (= `req` & ~`block`).
- `pkt_active`  output  1  a packet is mid-transfer: head popped, tail not yet popped.
- `count`  output  ADDR_W+1  current occupancy, 0..DEPTH.
- `stall_cnt`  output  8  saturating count of cycles with `req`=1 and `block`=1.

## Operation

- Storage: DEPTH entries of {tail, data}. `wr_ptr` and `rd_ptr` are ADDR_W wide and wrap modulo DEPTH. `count` is tracked separately.
- Push: occurs when `in_valid` & `in_ready`. Writes to `wr_ptr`, then `wr_ptr`+1.
- `in_ready` = (`count` != DEPTH). It is computed from registered `count` only. At full, no push is accepted even if a pop occurs in the same cycle.
- `req` = (`count` != 0). There is no bypass: a flit pushed into an empty buffer raises `req` the next cycle.
- `out_data`/`out_tail` = entry at `rd_ptr` (FWFT). When `count`=0 their value is don't-care.
- Pop: `pop` = `req` & ~`block`. On pop, `rd_ptr`+1.
- `count` update on each clock edge:
  - push and no pop: +1
  - pop and no push: −1
  - push and pop: unchanged
- Packet tracking is a two-state machine, IDLE/ACTIVE; `pkt_active`=1 in ACTIVE.
  - IDLE → ACTIVE: pop of a flit with `out_tail`=0.
  - ACTIVE → IDLE: pop of a flit with `out_tail`=1.
  - A single-flit packet (tail=1 popped in IDLE) stays in IDLE.
  - `pkt_active` is informational only. It does not gate `req`; the arbiter's block decision alone governs transfer.
- `stall_cnt`: increments on each cycle with `req`=1 and `block`=1. It saturates at 255 and clears only on reset.
- `in_valid` with `in_ready`=0 is ignored; the upstream stage must hold the flit.

## Timing

- Reset (asynchronous assert, takes effect immediately):
  - `wr_ptr`=0, `rd_ptr`=0, `count`=0, state=IDLE, `stall_cnt`=0.
  - Outputs therefore: `req`=0, `pop`=0, `in_ready`=1, `pkt_active`=0.
  - FIFO contents are not reset.
- Reset mid-packet discards all buffered flits and returns the state machine to IDLE.
- Latency: a flit pushed at edge N is at the head and `req`=1 after edge N, assuming an empty buffer. With `block`=0 it pops in that same cycle. Minimum transit is one cycle.
- Throughput: one push and one pop per cycle sustained when the buffer is neither full nor empty.
- `pop`, `req`, and `in_ready` are combinational from registers plus `block`. There is no combinational path from `in_valid` to `req`.
- Downstream: the arbiter's mux uses `out_data` in the same cycle `pop`=1.

## Test plan

- Reset/idle: assert `rst` mid-run with 3 flits buffered → immediately `count`=0, `req`=0, `in_ready`=1, `stall_cnt`=0, `pkt_active`=0.
- Fill/full: `block`=1, push 5 flits 0x11..0x15 on consecutive cycles → first 4 accepted; `count`=4, `in_ready`=0; 0x15 not accepted (upstream holds it); `out_data`=0x11.
- Drain order/wrap: continue from full with `block`=0 while pushing 0x15..0x18 → pops 0x11,0x12,… in order across pointer wrap; `count` constant while push and pop coincide.
- Simultaneous at full: `count`=4, `block`=0, `in_valid`=1 → pop occurs, push rejected, `count`=3 next cycle.
- Packet framing: push flits tail=0,0,1 then tail=1, `block`=0 → `pkt_active` is 1 from after first pop until after third pop, and stays 0 through the fourth (single-flit) pop.
- Stall counter: hold `block`=1 with `count`>0 for 300 cycles → `stall_cnt`=255; with `count`=0 and `block`=1 → no increment.
